gen_share_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one python2verilog-style generator instance (e.g. fib) among NREQ requesters.
- Latches the winning requester's argument and pulses the generator's start.
- Routes the generator's output stream, with backpressure, to the granted requester.
- Releases the grant when the generator signals done.
- Sits between top-level consumer logic and a single generator core.

---
 rtl/gen_share_arbiter.sv | 141 ++++++++++++++
 tb/tb_gen_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_share_arbiter.sv
// Round-robin arbiter that shares one streaming generator core among NREQ requesters.
// Optional stall watchdog is compiled in with `define GEN_TIMEOUT_EN.
module gen_share_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned W              = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              __clock,
  input  logic              __reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_n,
  output logic [NREQ-1:0]   grant,
  output logic [W-1:0]      out_data,
  output logic [NREQ-1:0]   out_valid,
  input  logic [NREQ-1:0]   out_ready,
  output logic [NREQ-1:0]   out_done,
  output logic              out_err,
  output logic [W-1:0]      gen_n,
  output logic              gen_start,
  output logic              gen_ready,
  input  logic [W-1:0]      gen_output_0,
  input  logic              gen_valid,
  input  logic              gen_done,
  output logic              gen_clear
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StStream, StClear, StFinish} state_e;

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            in_stream;
  int unsigned     cand;

  // First requesting index after the pointer, wrapping; the last winner scans last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr_q) + i) % NREQ;
      if (!pick_vld && req[IW'(cand)]) begin
        pick     = IW'(cand);
        pick_vld = 1'b1;
      end
    end
  end

  assign in_stream = (state_q == StStream);
  assign out_valid = (in_stream && gen_valid) ? grant : '0;
  assign gen_ready = in_stream & out_ready[idx_q];
  assign out_data  = in_stream ? gen_output_0 : '0;

`ifdef GEN_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_q;
  logic          clear_q;
  logic          err_q;
  assign gen_clear = clear_q;
  assign out_err   = err_q;
`else
  assign gen_clear = 1'b0;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge __clock or negedge __reset) begin
    if (!__reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= IW'(NREQ - 1);
      grant     <= '0;
      out_done  <= '0;
      gen_n     <= '0;
      gen_start <= 1'b0;
`ifdef GEN_TIMEOUT_EN
      stall_q   <= '0;
      clear_q   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            idx_q     <= pick;
            gen_n     <= req_n[int'(pick)*W +: W];
            grant     <= NREQ'(1) << pick;
            gen_start <= 1'b1;
            state_q   <= StStart;
          end
        end
        StStart: begin
          gen_start <= 1'b0;
`ifdef GEN_TIMEOUT_EN
          stall_q   <= '0;
`endif
          state_q   <= StStream;
        end
        StStream: begin
          if (gen_done) begin
            out_done <= grant;
            state_q  <= StFinish;
          end
`ifdef GEN_TIMEOUT_EN
          else if (gen_valid && out_ready[idx_q]) begin
            stall_q <= '0;
          end else if (stall_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Hung generator: clear it, then complete the job with an error.
            clear_q <= 1'b1;
            state_q <= StClear;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        StClear: begin
`ifdef GEN_TIMEOUT_EN
          clear_q  <= 1'b0;
          err_q    <= 1'b1;
`endif
          out_done <= grant;
          state_q  <= StFinish;
        end
        StFinish: begin
          out_done <= '0;
          grant    <= '0;
          ptr_q    <= idx_q;
`ifdef GEN_TIMEOUT_EN
          err_q    <= 1'b0;
`endif
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_share_arbiter.sv
// Scoreboard bench for gen_share_arbiter: a queue-based requester/arbitration model predicts
// grant order, beat data and completions; a negedge monitor pops and compares.
module tb_gen_share_arbiter;
  localparam int NREQ     = 4;
  localparam int W        = 16;
  localparam int TO       = 16;
  localparam int DONE_OK  = -1;
  localparam int DONE_ERR = -2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_n = '0;
  logic [NREQ-1:0]   grant;
  logic [W-1:0]      out_data;
  logic [NREQ-1:0]   out_valid;
  logic [NREQ-1:0]   out_ready = '1;
  logic [NREQ-1:0]   out_done;
  logic              out_err;
  logic [W-1:0]      gen_n;
  logic              gen_start;
  logic              gen_ready;
  logic [W-1:0]      gen_output_0;
  logic              gen_valid;
  logic              gen_done;
  logic              gen_clear;

  always #5 clk = ~clk;

  gen_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(TO)) dut (
    .__clock(clk), .__reset(rst_n), .req(req), .req_n(req_n), .grant(grant),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_done(out_done),
    .out_err(out_err), .gen_n(gen_n), .gen_start(gen_start), .gen_ready(gen_ready),
    .gen_output_0(gen_output_0), .gen_valid(gen_valid), .gen_done(gen_done),
    .gen_clear(gen_clear)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned jobq[NREQ][$];
  int          expq[NREQ][$];
  int          exp_grant[$];
  int          last_win = NREQ - 1;
  logic [NREQ-1:0] drop = '0;
  logic [NREQ-1:0] stall_mask = '0;
  int          ready_mode = 0;
  bit          bubble_en = 0;
  bit          mon_en = 0;
  int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int          pat_i = 0;

  // Generator model: beats 0..n-1, done on the accepted last beat.
  logic g_active, g_stall, bubble;
  int   g_k, g_n;
  assign gen_valid    = g_active && !g_stall && !bubble;
  assign gen_output_0 = W'(g_k);
  assign gen_done     = gen_valid && gen_ready && (g_k == g_n - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_active <= 1'b0; g_stall <= 1'b0; bubble <= 1'b0; g_k <= 0; g_n <= 0;
    end else begin
      bubble <= bubble_en && ($urandom_range(0, 3) == 0);
      if (gen_clear) g_active <= 1'b0;
      else if (gen_start) begin
        g_active <= 1'b1; g_k <= 0; g_n <= int'(gen_n);
        g_stall  <= |(stall_mask & grant);
      end else if (gen_valid && gen_ready) begin
        g_k <= g_k + 1;
        if (g_k == g_n - 1) g_active <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_job(input int r, input int n, input bit stall);
    jobq[r].push_back(n);
    if (!stall) for (int k = 0; k < n; k++) expq[r].push_back(k);
    expq[r].push_back(stall ? DONE_ERR : DONE_OK);
  endtask

  // Round-robin order for the jobs now queued, all requests held until served.
  task automatic predict();
    int cnt[NREQ];
    int p;
    for (int i = 0; i < NREQ; i++) cnt[i] = jobq[i].size();
    forever begin
      p = -1;
      for (int s = 1; s <= NREQ; s++)
        if (p < 0 && cnt[(last_win + s) % NREQ] > 0) p = (last_win + s) % NREQ;
      if (p < 0) break;
      exp_grant.push_back(p);
      cnt[p]--;
      last_win = p;
    end
  endtask

  // Requester driver: inputs change 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (jobq[i].size() > 0) && !drop[i];
      req_n[i*W +: W] = (jobq[i].size() > 0) ? W'(jobq[i][0]) : '0;
    end
    case (ready_mode)
      1: begin
`ifdef GEN_TIMEOUT_EN
        for (int i = 0; i < NREQ; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
`else
        out_ready = NREQ'($urandom);
`endif
      end
      2: begin
        out_ready    = '1;
        out_ready[0] = pat[pat_i][0];
        pat_i        = (pat_i + 1) % 7;
      end
      default: out_ready = '1;
    endcase
  end

  // Monitor / scoreboard.
  logic [NREQ-1:0] prev_grant = '0;
  bit              started = 0;
  int              cyc = 0;
  int              start_cyc = 0;
  int              cur;
  int              e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = '0; started = 0;
    end else if (mon_en) begin
      cyc++;
      cur = 0;
      for (int i = 0; i < NREQ; i++) if (grant[i]) cur = i;
      check("grant_onehot", $countones(grant) <= 1, 1);
      check("valid_outside_grant", out_valid & ~grant, 0);
      if (out_valid != 0) check("gen_ready_mirror", gen_ready, |(out_ready & grant));
      if (grant != 0 && prev_grant == 0) begin
        started = 0;
        if (exp_grant.size() == 0) check("grant_unexpected", exp_grant.size(), 1);
        else check("grant_order", grant, 1 << exp_grant.pop_front());
      end
      if (gen_start) begin
        check("start_once", started, 0);
        started   = 1;
        start_cyc = cyc;
        if (jobq[cur].size() > 0) check("gen_n", gen_n, jobq[cur][0]);
      end
`ifdef GEN_TIMEOUT_EN
      if (gen_clear) check("clear_delay", cyc - start_cyc, TO + 1);
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (expq[i].size() == 0) check("beat_extra", expq[i].size(), 1);
          else begin
            e = expq[i].pop_front();
            check("beat_data", out_data, e);
          end
        end
        if (out_done[i]) begin
          if (expq[i].size() == 0) check("done_extra", expq[i].size(), 1);
          else begin
            e = expq[i].pop_front();
            check("done_status", out_err ? DONE_ERR : DONE_OK, e);
          end
          check("done_gen_clear", gen_clear, 0);
          if (jobq[i].size() > 0) begin
            check("gen_n_stable", gen_n, jobq[i][0]);
            void'(jobq[i].pop_front());
          end
        end
      end
      prev_grant = grant;
    end
  end

  task automatic wait_idle(input string name);
    int b = 0;
    int busy = 1;
    while (busy != 0 && b < 3000) begin
      @(negedge clk);
      b++;
      busy = 0;
      for (int i = 0; i < NREQ; i++) busy += jobq[i].size();
    end
    check({name, "_drain"}, busy, 0);
    repeat (3) @(negedge clk);
    busy = exp_grant.size();
    for (int i = 0; i < NREQ; i++) busy += expq[i].size();
    check({name, "_leftover"}, busy, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_grant"}, grant, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_done"}, out_done, 0);
    check({name, "_out_err"}, out_err, 0);
    check({name, "_gen_n"}, gen_n, 0);
    check({name, "_gen_start"}, gen_start, 0);
    check({name, "_gen_ready"}, gen_ready, 0);
    check({name, "_gen_clear"}, gen_clear, 0);
    check({name, "_out_data"}, out_data, 0);
  endtask

  initial begin
    int b;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1;

    // Single job on requester 0.
    add_job(0, 3, 0); predict(); wait_idle("single");

    // All requesting, one-beat jobs.
    add_job(0, 1, 0); add_job(1, 1, 0); add_job(2, 1, 0); add_job(3, 1, 0); add_job(0, 1, 0);
    predict(); wait_idle("all_req");

    // Backpressure pattern on requester 0.
    pat_i = 0; ready_mode = 2;
    add_job(0, 4, 0); predict(); wait_idle("backpressure");
    ready_mode = 0;

    // Async reset mid-stream while beat 2 is pending.
    add_job(0, 5, 0); predict();
    b = 0;
    while (!(out_valid[0] && out_data == 2) && b < 200) begin @(negedge clk); b++; end
    check("reset_reach_beat2", b < 200, 1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    for (int i = 0; i < NREQ; i++) begin jobq[i].delete(); expq[i].delete(); end
    exp_grant.delete();
    last_win = NREQ - 1;
    @(negedge clk); rst_n = 1'b1;
    add_job(1, 3, 0); predict(); wait_idle("after_reset");

    // Request dropped one cycle after grant.
    add_job(2, 5, 0); predict();
    b = 0;
    while (!grant[2] && b < 200) begin @(negedge clk); b++; end
    check("drop_grant_seen", b < 200, 1);
    @(negedge clk); drop[2] = 1'b1;
    wait_idle("drop");
    drop[2] = 1'b0;

    // Randomised rounds with bubbles and random backpressure.
    bubble_en = 1; ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++)
        repeat ($urandom_range(0, 2)) add_job(i, $urandom_range(1, 6), 0);
      predict(); wait_idle("random");
    end
    bubble_en = 0; ready_mode = 0;

`ifdef GEN_TIMEOUT_EN
    // Hung generator on requester 3, normal job queued on requester 0.
    stall_mask = 4'b1000;
    add_job(3, 4, 1); add_job(0, 2, 0); predict(); wait_idle("timeout");
    stall_mask = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end

endmodule
